if_id_pipe: RTL and testbench
=============================

// Module: if_id_pipe
// PURPOSE
//  Parametrised IF->ID pipeline register; successor to the fixed 32-bit if/id latch.
//  Adds a valid/ready handshake, ID-side stall back-pressure and a synchronous flush
//    (branch/exception redirect).
//  Adds an optional one-entry skid buffer, so the upstream ready is driven from a
//    register and the fetch path has no combinational ready chain.
//  Sits between the fetch stage (PC/imem) and the decode stage.
// PARAMETERS
//  ADDR_W   32  width of PC field
//  INST_W   32  width of instruction field
//  SIDE_W    1  width of sideband tag (fetch exception / delay-slot flag)
//  SKID_EN   1  1: one-entry skid buffer, if_ready registered; 0: plain register, if_ready combinational
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous reset, active-high
//  flush     in   1       synchronous kill of all held and incoming beats
//  if_valid  in   1       fetch beat valid
//  if_ready  out  1       stage can accept a beat this cycle
//  if_pc     in   ADDR_W  fetch PC
//  if_inst   in   INST_W  fetched instruction
//  if_side   in   SIDE_W  sideband tag
//  id_valid  out  1       decode beat valid
//  id_ready  in   1       decode accepts beat (0 = ID stall)
//  id_pc     out  ADDR_W  PC to decode
//  id_inst   out  INST_W  instruction to decode
//  id_side   out  SIDE_W  sideband to decode
// BEHAVIOUR
//  Reset (async, rst=1):
//   - main and skid entries invalid; id_pc/id_inst/id_side = 0
//   - if_ready = 1 while rst=1 and on the first cycle after release
//  Transfer rules:
//   - Upstream transfer when if_valid & if_ready; downstream when id_valid & id_ready.
//   - Latency: a beat accepted at edge t appears on id_* after edge t (1 cycle).
//  Payload on empty stage:
//   - When id_valid=0, id_pc/id_inst/id_side read 0; id_inst=0 is a MIPS NOP.
//   - Payload updates only when a new beat is loaded.
//  SKID_EN=0:
//   - if_ready = ~id_valid | id_ready (combinational)
//   - Main register loads on upstream transfer.
//   - A drained main register with no new beat goes invalid and its payload goes to 0.
//  SKID_EN=1:
//   - if_ready = ~skid_valid (registered)
//   - States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
//   - EMPTY + accept -> ONE.
//   - ONE + accept + drain -> ONE (main <= new beat).
//   - ONE + accept + no drain -> FULL (skid <= new beat).
//   - ONE + drain, no accept -> EMPTY.
//   - FULL + drain -> ONE (main <= skid, skid cleared). No accept is possible in FULL.
//   - Beat order is strictly preserved; no beat is lost or duplicated.
//  Flush:
//   - flush=1 at an edge: main and skid invalid, payload 0; a beat offered that cycle
//     is consumed (if if_ready=1) and dropped.
//   - flush overrides all load/drain.
//   - id_valid=0 on the cycle after flush; if_ready=1 on the cycle after flush.
//  Simultaneous events:
//   - flush + id_ready + if_valid -> flush wins; the downstream handshake that cycle still
//     counts as taken by ID.
//  Reset mid-stream:
//   - All beats discarded immediately (async). No partial payload is visible.
// TESTING
//  1) Reset, then stream pc 0x100,0x104,0x108 with id_ready=1 -> id_pc shows the same
//     order, 1 cycle later, id_valid held high 3 cycles.
//  2) SKID_EN=1, id_ready=0 while 0x200,0x204 are offered -> 0x200 held on id_*;
//     if_ready=0 after 0x204 is captured. Raise id_ready -> 0x200 then 0x204, no loss.
//  3) SKID_EN=0, id_ready=0 with id_valid=1 -> if_ready=0 in the same cycle; id_* frozen.
//  4) FULL state, assert flush 1 cycle -> next cycle id_valid=0, id_inst=0, if_ready=1;
//     next accepted beat 0x300 appears normally.
//  5) Assert rst asynchronously mid-cycle with the stage FULL -> id_valid=0 and id_pc=0
//     before the next clk edge.
//  6) Random if_valid/id_ready/flush (10k cycles) -> scoreboard: in-order, no
//     duplicates, flushed beats never emitted.

Source files
------------

// File: rtl/if_id_pipe.sv
// IF->ID pipeline register with valid/ready handshake, ID stall back-pressure,
// synchronous flush and an optional one-entry skid buffer (registered if_ready).
module if_id_pipe #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int SIDE_W  = 1,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic [SIDE_W-1:0] if_side,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [SIDE_W-1:0] id_side
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [SIDE_W-1:0] side;
  } beat_t;

  // FULL is only ever reached with the skid buffer enabled.
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   accept;
  logic   drain;

  assign in_beat = '{pc: if_pc, inst: if_inst, side: if_side};

  // With the skid entry free, a beat can always be parked, so ready never
  // depends on id_ready; the plain register needs the combinational path.
  assign if_ready = SKID_EN ? (state_q != FULL)
                            : ((state_q == EMPTY) || id_ready);
  assign id_valid = (state_q != EMPTY);
  assign accept   = if_valid & if_ready;
  assign drain    = id_valid & id_ready;

  assign id_pc   = main_q.pc;
  assign id_inst = main_q.inst;
  assign id_side = main_q.side;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_beat;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = in_beat;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_beat;
          end else if (drain) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // NOTE: payload registers are reset too, because an empty stage must read
  // zero (a NOP) rather than stale data; use <= so all state updates together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed and randomized checks of if_id_pipe, skid (SKID_EN=1) and plain
// (SKID_EN=0) variants driven by the same stimulus.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [0:0]  if_side;
  logic        id_ready;

  logic        s_if_ready, s_id_valid;
  logic [31:0] s_id_pc, s_id_inst;
  logic [0:0]  s_id_side;
  logic        p_if_ready, p_id_valid;
  logic [31:0] p_id_pc, p_id_inst;
  logic [0:0]  p_id_side;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_pipe #(.ADDR_W(32), .INST_W(32), .SIDE_W(1), .SKID_EN(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(s_if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_side(if_side),
    .id_valid(s_id_valid), .id_ready(id_ready),
    .id_pc(s_id_pc), .id_inst(s_id_inst), .id_side(s_id_side)
  );

  if_id_pipe #(.ADDR_W(32), .INST_W(32), .SIDE_W(1), .SKID_EN(1'b0)) dut_plain (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(p_if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_side(if_side),
    .id_valid(p_id_valid), .id_ready(id_ready),
    .id_pc(p_id_pc), .id_inst(p_id_inst), .id_side(p_id_side)
  );

  // Instruction and sideband are derived from the PC so one number identifies a beat.
  task automatic offer(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = ~pc;
    if_side  = pc[2];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0; offer(1'b0, 32'h0);
    #2;
    checks++;
    if ({s_id_valid, s_id_pc, s_id_inst, s_id_side, s_if_ready} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_skid: got v=%b pc=%h inst=%h side=%b rdy=%b, want v=0 pc=0 inst=0 side=0 rdy=1",
               s_id_valid, s_id_pc, s_id_inst, s_id_side, s_if_ready);
    end
    checks++;
    if ({p_id_valid, p_id_pc, p_id_inst, p_id_side, p_if_ready} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_plain: got v=%b pc=%h inst=%h side=%b rdy=%b, want v=0 pc=0 inst=0 side=0 rdy=1",
               p_id_valid, p_id_pc, p_id_inst, p_id_side, p_if_ready);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({s_if_ready, p_if_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready: got skid=%b plain=%b, want 1 1", s_if_ready, p_if_ready);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, pcs[i]);
      step();
      checks++;
      if ({s_id_valid, s_id_pc, s_id_inst, s_id_side} !== {1'b1, pcs[i], ~pcs[i], pcs[i][2]}) begin
        errors++;
        $display("FAIL stream_skid[%0d]: got v=%b pc=%h inst=%h side=%b, want v=1 pc=%h",
                 i, s_id_valid, s_id_pc, s_id_inst, s_id_side, pcs[i]);
      end
      checks++;
      if ({p_id_valid, p_id_pc, p_id_inst, p_id_side} !== {1'b1, pcs[i], ~pcs[i], pcs[i][2]}) begin
        errors++;
        $display("FAIL stream_plain[%0d]: got v=%b pc=%h inst=%h side=%b, want v=1 pc=%h",
                 i, p_id_valid, p_id_pc, p_id_inst, p_id_side, pcs[i]);
      end
    end
    offer(1'b0, 32'h0);
    step();
    checks++;
    if ({s_id_valid, s_id_pc, s_id_inst, p_id_valid, p_id_pc, p_id_inst} !== {1'b0, 64'h0, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL stream_drained: got skid v=%b pc=%h inst=%h plain v=%b pc=%h inst=%h, want all 0",
               s_id_valid, s_id_pc, s_id_inst, p_id_valid, p_id_pc, p_id_inst);
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    offer(1'b1, 32'h200);
    step();
    checks++;
    if ({s_id_valid, s_id_pc, s_if_ready} !== {1'b1, 32'h200, 1'b1}) begin
      errors++;
      $display("FAIL stall_skid_one: got v=%b pc=%h rdy=%b, want v=1 pc=200 rdy=1", s_id_valid, s_id_pc, s_if_ready);
    end
    checks++;
    if ({p_id_valid, p_id_pc, p_if_ready} !== {1'b1, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL stall_plain_ready: got v=%b pc=%h rdy=%b, want v=1 pc=200 rdy=0", p_id_valid, p_id_pc, p_if_ready);
    end
    offer(1'b1, 32'h204);
    step();
    checks++;
    if ({s_id_valid, s_id_pc, s_if_ready} !== {1'b1, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL stall_skid_full: got v=%b pc=%h rdy=%b, want v=1 pc=200 rdy=0", s_id_valid, s_id_pc, s_if_ready);
    end
    checks++;
    if ({p_id_valid, p_id_pc, p_id_inst} !== {1'b1, 32'h200, ~32'h200}) begin
      errors++;
      $display("FAIL stall_plain_frozen: got v=%b pc=%h inst=%h, want v=1 pc=200 inst=fffffdff", p_id_valid, p_id_pc, p_id_inst);
    end
    offer(1'b0, 32'h0);
    id_ready = 1'b1;
    #1;
    checks++;
    if (p_if_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_plain_release: got rdy=%b, want 1", p_if_ready);
    end
    step();
    checks++;
    if ({s_id_valid, s_id_pc, s_id_inst, p_id_valid} !== {1'b1, 32'h204, ~32'h204, 1'b0}) begin
      errors++;
      $display("FAIL stall_skid_second: got skid v=%b pc=%h inst=%h plain v=%b, want skid v=1 pc=204 plain v=0",
               s_id_valid, s_id_pc, s_id_inst, p_id_valid);
    end
    step();
    checks++;
    if ({s_id_valid, s_id_pc, s_if_ready} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL stall_skid_empty: got v=%b pc=%h rdy=%b, want v=0 pc=0 rdy=1", s_id_valid, s_id_pc, s_if_ready);
    end
  endtask

  task automatic fill_full();
    id_ready = 1'b0;
    offer(1'b1, 32'h2A0);
    step();
    offer(1'b1, 32'h2A4);
    step();
    offer(1'b0, 32'h0);
  endtask

  task automatic test_flush();
    fill_full();
    checks++;
    if (s_if_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefull: got rdy=%b, want 0", s_if_ready);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({s_id_valid, s_id_inst, s_if_ready} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL flush_skid: got v=%b inst=%h rdy=%b, want v=0 inst=0 rdy=1", s_id_valid, s_id_inst, s_if_ready);
    end
    checks++;
    if ({p_id_valid, p_id_inst, p_if_ready} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL flush_plain: got v=%b inst=%h rdy=%b, want v=0 inst=0 rdy=1", p_id_valid, p_id_inst, p_if_ready);
    end
    id_ready = 1'b1;
    offer(1'b1, 32'h300);
    step();
    offer(1'b0, 32'h0);
    checks++;
    if ({s_id_valid, s_id_pc, p_id_valid, p_id_pc} !== {1'b1, 32'h300, 1'b1, 32'h300}) begin
      errors++;
      $display("FAIL flush_next_beat: got skid v=%b pc=%h plain v=%b pc=%h, want v=1 pc=300 for both",
               s_id_valid, s_id_pc, p_id_valid, p_id_pc);
    end
    step();
    // A beat offered during flush is consumed and never emitted.
    offer(1'b1, 32'h3F0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0);
    checks++;
    if ({s_id_valid, p_id_valid} !== 2'b00) begin
      errors++;
      $display("FAIL flush_drops_offer: got skid v=%b plain v=%b, want 0 0", s_id_valid, p_id_valid);
    end
  endtask

  task automatic test_async_reset();
    fill_full();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({s_id_valid, s_id_pc, s_id_inst, p_id_valid, p_id_pc} !== {1'b0, 64'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: got skid v=%b pc=%h inst=%h plain v=%b pc=%h, want all 0",
               s_id_valid, s_id_pc, s_id_inst, p_id_valid, p_id_pc);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({s_if_ready, s_id_valid} !== 2'b10) begin
      errors++;
      $display("FAIL async_reset_release: got rdy=%b v=%b, want rdy=1 v=0", s_if_ready, s_id_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] sq[$];
    logic [31:0] pq[$];
    logic [31:0] next_pc = 32'h1000;
    logic        s_acc, p_acc, s_drn, p_drn;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      offer($urandom_range(0, 3) != 0, next_pc);
      id_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (s_id_valid !== (sq.size() != 0) || (s_id_valid === 1'b1 &&
          {s_id_pc, s_id_inst, s_id_side} !== {sq[0], ~sq[0], sq[0][2]})) begin
        errors++;
        $display("FAIL rand_skid cyc %0d: got v=%b pc=%h, want v=%b pc=%h",
                 cyc, s_id_valid, s_id_pc, sq.size() != 0, (sq.size() != 0) ? sq[0] : 32'h0);
      end
      checks++;
      if (p_id_valid !== (pq.size() != 0) || (p_id_valid === 1'b1 &&
          {p_id_pc, p_id_inst, p_id_side} !== {pq[0], ~pq[0], pq[0][2]})) begin
        errors++;
        $display("FAIL rand_plain cyc %0d: got v=%b pc=%h, want v=%b pc=%h",
                 cyc, p_id_valid, p_id_pc, pq.size() != 0, (pq.size() != 0) ? pq[0] : 32'h0);
      end
      checks++;
      if (s_if_ready !== (sq.size() < 2) || p_if_ready !== (pq.size() == 0 || id_ready)) begin
        errors++;
        $display("FAIL rand_ready cyc %0d: got skid=%b plain=%b, want skid=%b plain=%b",
                 cyc, s_if_ready, p_if_ready, sq.size() < 2, pq.size() == 0 || id_ready);
      end
      s_acc = if_valid & s_if_ready;
      p_acc = if_valid & p_if_ready;
      s_drn = s_id_valid & id_ready;
      p_drn = p_id_valid & id_ready;
      @(posedge clk);
      if (s_drn && sq.size() != 0) void'(sq.pop_front());
      if (p_drn && pq.size() != 0) void'(pq.pop_front());
      if (flush) begin
        sq.delete();
        pq.delete();
      end else begin
        if (s_acc) sq.push_back(if_pc);
        if (p_acc) pq.push_back(if_pc);
      end
      if (if_valid) next_pc = next_pc + 32'd4;
      #1;
    end
    offer(1'b0, 32'h0);
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
